// File: rtl/prf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prf_arb_pkg
// Brief   : Shared widths and operand-request type for the PRF read arbiter
//           and the issue queues that feed it.
// Rev     : 1.0  initial release
// ============================================================================
package prf_arb_pkg;

    localparam int PRF_REQ_COUNT    = 4;
    localparam int PRF_MAX_OPERANDS = 3;
    localparam int PRF_PRN_BITS     = 6;
    localparam int PRF_INST_ID_BITS = 6;
    localparam int PRF_WB_PORTS     = 4;
    localparam int PRF_DATA_BITS    = 64;

    // Architectural zero register when ZERO_PRN_EN is defined.
    localparam int ZERO_PRN = 0;

    typedef struct packed {
        logic                    en;
        logic [PRF_PRN_BITS-1:0] prn;
    } opnd_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin one-hot arbiter; scan starts at i_ptr and the next
//           pointer is one past the winner.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int REQ_COUNT = 4,
    parameter int PTR_W     = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
    input  logic [REQ_COUNT-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [REQ_COUNT-1:0] o_gnt,
    output logic [PTR_W-1:0]     o_gnt_idx,
    output logic                 o_gnt_valid,
    output logic [PTR_W-1:0]     o_next_ptr
);

    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= REQ_COUNT) s = s - REQ_COUNT;
        return PTR_W'(s);
    endfunction

    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (!o_gnt_valid && i_req[rot_idx(i_ptr, i)]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = rot_idx(i_ptr, i);
            end
        end
    end

    assign o_gnt      = o_gnt_valid ? (REQ_COUNT'(1) << o_gnt_idx) : '0;
    assign o_next_ptr = (o_gnt_idx == PTR_W'(REQ_COUNT - 1)) ? '0
                                                             : o_gnt_idx + PTR_W'(1);

endmodule
`default_nettype wire

// File: rtl/prf_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : prf_read_arbiter
// Brief   : Shares the PRF read ports among issue queues round-robin and
//           returns bypassed operand data one cycle after the grant.
//           Optional macro ZERO_PRN_EN makes PRN 0 a hardwired zero.
// Rev     : 1.0  initial release
// ============================================================================
module prf_read_arbiter
    import prf_arb_pkg::*;
#(
    parameter int REQ_COUNT    = PRF_REQ_COUNT,
    parameter int MAX_OPERANDS = PRF_MAX_OPERANDS,
    parameter int PRN_BITS     = PRF_PRN_BITS,
    parameter int INST_ID_BITS = PRF_INST_ID_BITS,
    parameter int WB_PORTS     = PRF_WB_PORTS
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        flush,
    input  logic [REQ_COUNT-1:0]                        req_valid,
    input  logic [REQ_COUNT-1:0][INST_ID_BITS-1:0]      req_tag,
    input  logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0]      req_en,
    input  logic [REQ_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] req_prn,
    output logic [REQ_COUNT-1:0]                        gnt,
    output logic [MAX_OPERANDS-1:0]                     prf_read_enable,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]       prf_read_prn,
    input  logic [MAX_OPERANDS-1:0][PRF_DATA_BITS-1:0]  prf_rdata,
    input  logic [WB_PORTS-1:0]                         wb_valid,
    input  logic [WB_PORTS-1:0][PRN_BITS-1:0]           wb_prn,
    input  logic [WB_PORTS-1:0][PRF_DATA_BITS-1:0]      wb_data,
    output logic [REQ_COUNT-1:0]                        rsp_valid,
    output logic [INST_ID_BITS-1:0]                     rsp_tag,
    output logic [MAX_OPERANDS-1:0][PRF_DATA_BITS-1:0]  rsp_data
);

    localparam int PTR_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

    logic [REQ_COUNT-1:0]          w_req_live;
    logic [REQ_COUNT-1:0]          w_gnt;
    logic [PTR_W-1:0]              w_gnt_idx;
    logic                          w_gnt_valid;
    logic [PTR_W-1:0]              w_next_ptr;
    logic [PTR_W-1:0]              r_rr_ptr;

    logic                          r_stage_valid;
    logic [PTR_W-1:0]              r_stage_req;
    logic [INST_ID_BITS-1:0]       r_stage_tag;
    opnd_req_t [MAX_OPERANDS-1:0]  r_stage_opnd;
    logic                          w_rsp_live;

    // Holding reset or flush hides every request, so no grant can leak out.
    assign w_req_live = (rst_n && !flush) ? req_valid : '0;

    rr_arbiter #(
        .REQ_COUNT (REQ_COUNT),
        .PTR_W     (PTR_W)
    ) u_rr_arbiter (
        .i_req       (w_req_live),
        .i_ptr       (r_rr_ptr),
        .o_gnt       (w_gnt),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid),
        .o_next_ptr  (w_next_ptr)
    );

    assign gnt = w_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_valid) begin
            r_rr_ptr <= w_next_ptr;
        end
    end

    generate
        for (genvar o = 0; o < MAX_OPERANDS; o++) begin : g_rd_issue
            logic w_rd_zero;
`ifdef ZERO_PRN_EN
            assign w_rd_zero = (req_prn[w_gnt_idx][o] == PRN_BITS'(ZERO_PRN));
`else
            assign w_rd_zero = 1'b0;
`endif
            assign prf_read_enable[o] = w_gnt_valid && req_en[w_gnt_idx][o] && !w_rd_zero;
            assign prf_read_prn[o]    = w_gnt_valid ? req_prn[w_gnt_idx][o] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_valid <= 1'b0;
            r_stage_req   <= '0;
            r_stage_tag   <= '0;
            r_stage_opnd  <= '0;
        end else begin
            r_stage_valid <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_stage_req <= w_gnt_idx;
                r_stage_tag <= req_tag[w_gnt_idx];
                for (int o = 0; o < MAX_OPERANDS; o++) begin
                    r_stage_opnd[o].en  <= req_en[w_gnt_idx][o];
                    r_stage_opnd[o].prn <= PRF_PRN_BITS'(req_prn[w_gnt_idx][o]);
                end
            end
        end
    end

    assign w_rsp_live = r_stage_valid && !flush;
    assign rsp_valid  = w_rsp_live ? (REQ_COUNT'(1) << r_stage_req) : '0;
    assign rsp_tag    = w_rsp_live ? r_stage_tag : '0;

    generate
        for (genvar o = 0; o < MAX_OPERANDS; o++) begin : g_rsp
            logic [PRN_BITS-1:0]      w_stage_prn;
            logic                     w_stage_zero;
            logic                     w_byp_hit;
            logic [PRF_DATA_BITS-1:0] w_byp_data;

            assign w_stage_prn = PRN_BITS'(r_stage_opnd[o].prn);
`ifdef ZERO_PRN_EN
            assign w_stage_zero = (w_stage_prn == PRN_BITS'(ZERO_PRN));
`else
            assign w_stage_zero = 1'b0;
`endif

            // Lowest-numbered matching writeback port wins; this also picks up
            // a PRF write that lands in the same cycle as the read.
            always_comb begin
                w_byp_hit  = 1'b0;
                w_byp_data = '0;
                for (int w = 0; w < WB_PORTS; w++) begin
                    if (!w_byp_hit && wb_valid[w] && (wb_prn[w] == w_stage_prn)) begin
                        w_byp_hit  = 1'b1;
                        w_byp_data = wb_data[w];
                    end
                end
            end

            assign rsp_data[o] = (!w_rsp_live || !r_stage_opnd[o].en || w_stage_zero) ? '0 :
                                 w_byp_hit ? w_byp_data : prf_rdata[o];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_prf_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_prf_read_arbiter
// Brief   : Self-checking bench: vector table for arbitration plus scoreboard
//           of expected responses, and hand sequences for corner cases.
// Rev     : 1.0  initial release
// ============================================================================
module tb_prf_read_arbiter;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic [3:0]             req_valid;
    logic [3:0][5:0]        req_tag;
    logic [3:0][2:0]        req_en;
    logic [3:0][2:0][5:0]   req_prn;
    logic [3:0]             gnt;
    logic [2:0]             prf_read_enable;
    logic [2:0][5:0]        prf_read_prn;
    logic [2:0][63:0]       prf_rdata;
    logic [3:0]             wb_valid;
    logic [3:0][5:0]        wb_prn;
    logic [3:0][63:0]       wb_data;
    logic [3:0]             rsp_valid;
    logic [5:0]             rsp_tag;
    logic [2:0][63:0]       rsp_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req_valid;
        logic       flush;
        logic [3:0] exp_gnt;
    } vec_t;

    typedef struct {
        int              q;
        logic [5:0]      tag;
        logic [2:0]      en;
        logic [2:0][5:0] prn;
    } sb_t;

    vec_t tbl[17];
    sb_t  sb[$];

    prf_read_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .req_valid       (req_valid),
        .req_tag         (req_tag),
        .req_en          (req_en),
        .req_prn         (req_prn),
        .gnt             (gnt),
        .prf_read_enable (prf_read_enable),
        .prf_read_prn    (prf_read_prn),
        .prf_rdata       (prf_rdata),
        .wb_valid        (wb_valid),
        .wb_prn          (wb_prn),
        .wb_data         (wb_data),
        .rsp_valid       (rsp_valid),
        .rsp_tag         (rsp_tag),
        .rsp_data        (rsp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_data(input logic en, input logic [5:0] prn, input int o);
        if (!en) return 64'h0;
`ifdef ZERO_PRN_EN
        if (prn == 6'd0) return 64'h0;
`endif
        for (int w = 0; w < 4; w++)
            if (wb_valid[w] && wb_prn[w] == prn) return wb_data[w];
        return prf_rdata[o];
    endfunction

    // Inputs are already driven at the falling edge; check, then advance one cycle.
    task automatic do_cycle(input logic [3:0] exp_gnt);
        sb_t             e;
        int              g;
        logic [2:0]      xen;
        logic [2:0][5:0] xprn;
        logic [3:0]      xrv;
        logic [5:0]      xtag;
        logic [2:0][63:0] xdata;
        #2;
        g = -1;
        for (int i = 0; i < 4; i++) if (exp_gnt[i]) g = i;
        xen = '0;
        xprn = '0;
        if (g >= 0) begin
            for (int o = 0; o < 3; o++) begin
                xen[o]  = req_en[g][o];
                xprn[o] = req_prn[g][o];
`ifdef ZERO_PRN_EN
                if (req_prn[g][o] == 6'd0) xen[o] = 1'b0;
`endif
            end
        end
        chk("gnt", 64'(gnt), 64'(exp_gnt));
        chk("prf_read_enable", 64'(prf_read_enable), 64'(xen));
        chk("prf_read_prn", 64'(prf_read_prn), 64'(xprn));

        xrv = '0;
        xtag = '0;
        xdata = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!flush) begin
                xrv  = 4'(1) << e.q;
                xtag = e.tag;
                for (int o = 0; o < 3; o++) xdata[o] = model_data(e.en[o], e.prn[o], o);
            end
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(xrv));
        chk("rsp_tag", 64'(rsp_tag), 64'(xtag));
        for (int o = 0; o < 3; o++) chk($sformatf("rsp_data[%0d]", o), rsp_data[o], xdata[o]);

        if (g >= 0) begin
            e.q   = g;
            e.tag = req_tag[g];
            e.en  = req_en[g];
            e.prn = req_prn[g];
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_rdata();
        for (int o = 0; o < 3; o++) prf_rdata[o] = {$urandom, $urandom};
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0010};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0100};
        tbl[7]  = '{4'b1111, 1'b0, 4'b1000};
        tbl[8]  = '{4'b0001, 1'b1, 4'b0000};
        tbl[9]  = '{4'b0001, 1'b0, 4'b0001};
        tbl[10] = '{4'b1001, 1'b0, 4'b1000};
        tbl[11] = '{4'b0110, 1'b0, 4'b0010};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000};
        tbl[13] = '{4'b0010, 1'b0, 4'b0010};
        tbl[14] = '{4'b0010, 1'b0, 4'b0010};
        tbl[15] = '{4'b1111, 1'b1, 4'b0000};
        tbl[16] = '{4'b1111, 1'b0, 4'b0100};

        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b1111;
        wb_valid  = '0;
        wb_prn    = '0;
        wb_data   = '0;
        for (int r = 0; r < 4; r++) begin
            req_tag[r] = 6'(r * 5 + 3);
            req_en[r]  = 3'($urandom_range(1, 7));
            for (int o = 0; o < 3; o++) req_prn[r][o] = 6'($urandom_range(1, 63));
        end
        rand_rdata();

        @(negedge clk);
        #2;
        chk("reset gnt", 64'(gnt), 64'h0);
        chk("reset prf_read_enable", 64'(prf_read_enable), 64'h0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset rsp_tag", 64'(rsp_tag), 64'h0);
        chk("reset rsp_data", 64'(rsp_data[0] | rsp_data[1] | rsp_data[2]), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            req_valid = tbl[i].req_valid;
            flush     = tbl[i].flush;
            rand_rdata();
            do_cycle(tbl[i].exp_gnt);
        end
        flush = 1'b0;

        // Queue 2 alone: prn {5,9,0}, en {1,1,0}; data from PRF.
        req_valid = 4'b0100;
        req_en[2] = 3'b011;
        req_prn[2][0] = 6'd5;
        req_prn[2][1] = 6'd9;
        req_prn[2][2] = 6'd0;
        rand_rdata();
        do_cycle(4'b0100);
        req_valid = 4'b0000;
        prf_rdata[0] = 64'hA;
        prf_rdata[1] = 64'hB;
        do_cycle(4'b0000);

        // Same read with two writeback ports hitting PRN 9 in the response cycle.
        req_valid = 4'b0100;
        rand_rdata();
        do_cycle(4'b0100);
        req_valid = 4'b0000;
        prf_rdata[0] = 64'hA;
        prf_rdata[1] = 64'hB;
        wb_valid   = 4'b1010;
        wb_prn[1]  = 6'd9;
        wb_prn[3]  = 6'd9;
        wb_data[1] = 64'h77;
        wb_data[3] = 64'h99;
        #2;
        chk("bypass lowest port", rsp_data[1], 64'h77);
        do_cycle(4'b0000);
        wb_valid = '0;

        // Reset between grant and response; pointer must restart at queue 0.
        req_valid = 4'b0010;
        do_cycle(4'b0010);
        rst_n = 1'b0;
        req_valid = 4'b0101;
        #2;
        chk("midreset gnt", 64'(gnt), 64'h0);
        chk("midreset rsp_valid", 64'(rsp_valid), 64'h0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(4'b0001);
        req_valid = 4'b0000;
        do_cycle(4'b0000);

        // PRN 0 operand with a writeback also targeting PRN 0.
        req_valid = 4'b0001;
        req_en[0] = 3'b111;
        req_prn[0][0] = 6'd0;
        req_prn[0][1] = 6'd7;
        req_prn[0][2] = 6'd8;
        do_cycle(4'b0001);
        req_valid  = 4'b0000;
        wb_valid   = 4'b0001;
        wb_prn[0]  = 6'd0;
        wb_data[0] = 64'h55;
        rand_rdata();
        do_cycle(4'b0000);
        wb_valid = '0;
        do_cycle(4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
